// File: rtl/dr_word_collector_if.sv
// Bundle between the dual-rail gate network, the collector and the word consumer.
// The master side drives the rails and out_ready; the slave side is the collector.
interface dr_word_collector_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din_p;
    logic [WIDTH-1:0] din_n;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] out_conflict;
    logic [WIDTH-1:0] out_unres;
    logic             out_timeout;
    logic             overrun;

    modport master (
        output din_p, din_n, out_ready,
        input  in_ready, out_valid, out_data, out_conflict, out_unres, out_timeout, overrun
    );

    modport slave (
        input  din_p, din_n, out_ready,
        output in_ready, out_valid, out_data, out_conflict, out_unres, out_timeout, overrun
    );
endinterface

// File: rtl/dr_word_collector.sv
// Completion detector for dual-rail words: gathers rail pulses per bit until the word
// resolves (or times out) and presents the decoded word with a valid/ready handshake.
module dr_word_collector #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    dr_word_collector_if.slave   bus,
    output logic [1:0]           state_dbg
);
    // Handshake: a word moves when out_valid & out_ready are both high on a rising
    // edge; out_valid never drops and out_* never change until that happens.
    // Rails are only taken while in_ready is high; anything else is dropped and
    // reported on overrun one cycle later.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] got_p;
    logic [WIDTH-1:0] got_n;
    logic [WIDTH-1:0] nxt_p;
    logic [WIDTH-1:0] nxt_n;
    logic             rail_any;
    logic             complete;
    logic             enter_hold;
    logic             timed_out;

    // Completion looks at this cycle's rails too, so a word finishing now leaves next cycle.
    assign nxt_p    = got_p | bus.din_p;
    assign nxt_n    = got_n | bus.din_n;
    assign complete = &(nxt_p | nxt_n);
    assign rail_any = |(bus.din_p | bus.din_n);

    assign timed_out  = (state == COLLECT) && !complete && (cnt == CNT_LAST);
    assign enter_hold = ((state == IDLE) && rail_any && complete) ||
                        ((state == COLLECT) && (complete || timed_out));

    assign bus.in_ready = (state != HOLD);
    assign state_dbg    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            got_p            <= '0;
            got_n            <= '0;
            bus.out_valid    <= 1'b0;
            bus.out_data     <= '0;
            bus.out_conflict <= '0;
            bus.out_unres    <= '0;
            bus.out_timeout  <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            bus.overrun <= (state == HOLD) && rail_any;

            case (state)
                IDLE: begin
                    if (rail_any) begin
                        got_p <= bus.din_p;
                        got_n <= bus.din_n;
                        if (complete) begin
                            state <= HOLD;
                        end else begin
                            state <= COLLECT;
                            cnt   <= '0;
                        end
                    end
                end
                COLLECT: begin
                    got_p <= nxt_p;
                    got_n <= nxt_n;
                    if (complete || timed_out) begin
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        got_p         <= '0;
                        got_n         <= '0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A conflicting bit decodes as 1 and also shows up in out_conflict.
            if (enter_hold) begin
                bus.out_valid    <= 1'b1;
                bus.out_data     <= nxt_p;
                bus.out_conflict <= nxt_p & nxt_n;
                bus.out_unres    <= ~(nxt_p | nxt_n);
                bus.out_timeout  <= timed_out;
            end
        end
    end
endmodule
